sat_alu_pipe: RTL and testbench

Two-stage, valid/ready pipelined saturating arithmetic unit with a persistent accumulator, parametrised in width and selectable signed/unsigned per operation. Next-generation successor to the team's combinational saturating adder. Serves as the clamp-on-overflow datapath for DSP-style extensions and fixed-point sequences. Adds subtraction, unsigned mode, accumulation across transactions, per-result saturation flags and a sticky overflow status.

---
 rtl/sat_alu_pipe.sv | 164 ++++++++++++++++
 tb/tb_sat_alu_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_alu_pipe.sv
// sat_alu_pipe
//   Two-stage valid/ready saturating arithmetic unit with a persistent
//   accumulator. Stage S1 captures the request with its operands widened
//   to WIDTH+2 bits. Stage S2 computes and clamps the result, registers it,
//   and updates the accumulator and the sticky saturation flag.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    request valid
//   in_ready    request accepted when in_valid && in_ready
//   op          00 ADD, 01 SUB, 10 ACC (acc + a), 11 LOAD (acc <= a)
//   is_signed   1: two's-complement limits, 0: unsigned limits
//   a, b        operands (b ignored by ACC and LOAD)
//   out_valid   result valid
//   out_ready   result consumed when out_valid && out_ready
//   result      clamped result
//   sat         result was clamped
//   acc         accumulator register
//   sat_sticky  set by any clamped result, cleared by clr_sticky
//   clr_sticky  synchronous clear of sat_sticky (a same-cycle set wins)
module sat_alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             sat,
  output logic [WIDTH-1:0] acc,
  output logic             sat_sticky,
  input  logic             clr_sticky
);

  // Two guard bits hold any sum or difference of two WIDTH-bit operands,
  // signed or unsigned, without wrapping.
  localparam int XW = WIDTH + 2;

  localparam logic signed [XW-1:0] S_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] S_MIN = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0] U_MAX = {2'b00, {WIDTH{1'b1}}};
  localparam logic signed [XW-1:0] U_MIN = {XW{1'b0}};

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  function automatic logic signed [XW-1:0] extend(input logic [WIDTH-1:0] v,
                                                  input logic sgn);
    extend = sgn ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
  endfunction

  // ---------------------------------------------------------------- handshake
  logic s1_valid;
  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;

  // ---------------------------------------------------------------- stage S1
  op_t                   s1_op;
  logic                  s1_signed;
  logic signed [XW-1:0]  s1_a;
  logic signed [XW-1:0]  s1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_signed <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op     <= op_t'(op);
        s1_signed <= is_signed;
        s1_a      <= extend(a, is_signed);
        s1_b      <= extend(b, is_signed);
      end
    end
  end

  // ------------------------------------------------- stage S2 combinational
  logic signed [XW-1:0] acc_x;
  logic signed [XW-1:0] raw;
  logic signed [XW-1:0] limit_hi;
  logic signed [XW-1:0] limit_lo;
  logic                 over;
  logic                 under;
  logic [WIDTH-1:0]     res_nxt;
  logic                 sat_nxt;
  logic                 writes_acc;
  logic                 s2_load;

  always_comb begin
    // acc is reinterpreted under the mode of the op that consumes it.
    acc_x = extend(acc, s1_signed);
    raw   = s1_a;
    case (s1_op)
      OP_ADD:  raw = s1_a + s1_b;
      OP_SUB:  raw = s1_a - s1_b;
      OP_ACC:  raw = acc_x + s1_a;
      default: raw = s1_a;
    endcase

    limit_hi = s1_signed ? S_MAX : U_MAX;
    limit_lo = s1_signed ? S_MIN : U_MIN;
    over     = raw > limit_hi;
    under    = raw < limit_lo;

    res_nxt = raw[WIDTH-1:0];
    if (over) begin
      res_nxt = limit_hi[WIDTH-1:0];
    end else if (under) begin
      res_nxt = limit_lo[WIDTH-1:0];
    end
    // LOAD passes an in-range operand through, so it never clamps.
    sat_nxt = over || under;

    writes_acc = (s1_op == OP_ACC) || (s1_op == OP_LOAD);
    s2_load    = advance && s1_valid;
  end

  // ---------------------------------------------------------------- stage S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
      acc       <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_nxt;
        sat    <= sat_nxt;
        if (writes_acc) begin
          acc <= res_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
    end else if (s2_load && sat_nxt) begin
      sat_sticky <= 1'b1;
    end else if (clr_sticky) begin
      sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sat_alu_pipe.sv
// tb_sat_alu_pipe
//   Scoreboard bench for sat_alu_pipe at WIDTH=8. Expected results are
//   computed by an integer model when a request is accepted and compared
//   in order when the DUT retires a result.
module tb_sat_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         sat;
  logic [W-1:0] acc;
  logic         sat_sticky;
  logic         clr_sticky = 1'b0;

  sat_alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .sat        (sat),
    .acc        (acc),
    .sat_sticky (sat_sticky),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         sat;
    logic [W-1:0] accv;
  } exp_t;

  exp_t         sb[$];
  int           ov_cycles[$];
  int           acc_cycles[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc_n = 0;
  logic         accepted = 1'b0;
  logic [W-1:0] m_acc = '0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic s,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       output exp_t e);
    int av, bv, cv, raw, hi, lo;
    av = s ? int'($signed(x)) : int'(x);
    bv = s ? int'($signed(y)) : int'(y);
    cv = s ? int'($signed(m_acc)) : int'(m_acc);
    case (o)
      2'b00:   raw = av + bv;
      2'b01:   raw = av - bv;
      2'b10:   raw = cv + av;
      default: raw = av;
    endcase
    hi = s ? (1 << (W-1)) - 1 : (1 << W) - 1;
    lo = s ? -(1 << (W-1)) : 0;
    e.sat = 1'b0;
    if (raw > hi) begin
      raw = hi;
      e.sat = 1'b1;
    end else if (raw < lo) begin
      raw = lo;
      e.sat = 1'b1;
    end
    e.res = raw[W-1:0];
    if (o[1]) m_acc = e.res;
    e.accv = m_acc;
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic cyc();
    exp_t e;
    #1;
    if (out_valid) ov_cycles.push_back(cyc_n);
    if (out_valid && out_ready) begin
      check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("result", result, e.res);
        check_val("sat", sat, e.sat);
        check_val("acc", acc, e.accv);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) begin
      model(op, is_signed, a, b, e);
      sb.push_back(e);
      acc_cycles.push_back(cyc_n);
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic send(input logic [1:0] o, input logic s,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; is_signed = s; a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (accepted) break;
    end
    check_val("accept", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) cyc();
    check_val("drain", sb.size(), 0);
  endtask

  logic [W-1:0] va [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
  logic [W-1:0] vb [4] = '{8'd1, 8'd2, 8'd3, 8'd4};

  initial begin
    int idx;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_sat", sat, 0);
    check_val("rst_acc", acc, 0);
    check_val("rst_sticky", sat_sticky, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // signed overflow then a clean add; sticky persists
    send(2'b00, 1'b1, 8'd100, 8'd50);
    drain();
    check_val("sticky_set", sat_sticky, 1);
    send(2'b00, 1'b1, 8'd3, 8'd4);
    drain();
    check_val("sticky_hold", sat_sticky, 1);

    // limit cases in both modes
    send(2'b01, 1'b0, 8'd5, 8'd10);
    send(2'b01, 1'b1, 8'h80, 8'd1);
    send(2'b00, 1'b0, 8'd200, 8'd100);
    drain();

    // back-to-back accumulate stream
    ov_cycles.delete();
    acc_cycles.delete();
    send(2'b11, 1'b1, 8'd120, 8'd0);
    send(2'b10, 1'b1, 8'd5, 8'd0);
    send(2'b10, 1'b1, 8'd5, 8'd0);
    send(2'b10, 1'b1, 8'hEC, 8'd0);
    drain();
    check_val("stream_ov_count", ov_cycles.size(), 4);
    if (ov_cycles.size() == 4 && acc_cycles.size() == 4) begin
      check_val("stream_accept_rate", acc_cycles[3] - acc_cycles[0], 3);
      check_val("stream_latency", ov_cycles[0] - acc_cycles[0], 2);
      check_val("stream_ov_consec", ov_cycles[3] - ov_cycles[0], 3);
    end
    check_val("stream_acc", acc, 8'd107);

    // backpressure: 5 stalled cycles while offering 4 ADDs
    idx = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op = 2'b00; is_signed = 1'b1;
      a = va[idx < 4 ? idx : 3]; b = vb[idx < 4 ? idx : 3];
      in_valid = 1'b1;
      cyc();
      if (accepted) idx++;
      if (i >= 2) begin
        check_val("stall_result", result, 8'd11);
        check_val("stall_in_ready", in_ready, 0);
      end
    end
    check_val("stall_accepts", idx, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      a = va[idx]; b = vb[idx];
      cyc();
      if (accepted) idx++;
    end
    in_valid = 1'b0;
    check_val("bp_accepts", idx, 4);
    drain();

    // sticky clear vs same-cycle set
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    check_val("sticky_clr", sat_sticky, 0);
    send(2'b00, 1'b1, 8'd100, 8'd50);
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    check_val("sticky_set_wins", sat_sticky, 1);
    clr_sticky = 1'b1;
    cyc();
    clr_sticky = 1'b0;
    check_val("sticky_clr2", sat_sticky, 0);
    drain();

    // reset during an in-flight ACC
    send(2'b11, 1'b1, 8'd120, 8'd0);
    send(2'b10, 1'b1, 8'd100, 8'd0);
    drain();
    check_val("pre_rst_acc", acc, 8'd127);
    check_val("pre_rst_sticky", sat_sticky, 1);
    send(2'b10, 1'b1, 8'd10, 8'd0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_acc", acc, 0);
    check_val("mid_rst_sticky", sat_sticky, 0);
    sb.delete();
    m_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b10, 1'b1, 8'd5, 8'd0);
    drain();
    check_val("post_rst_acc", acc, 8'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
